sensor_emu_gen2: RTL and testbench

Second-generation sensor-emulator frame generator. It turns a stream of bit-patterns from the emulator control path into LVDS frame data: idle pattern, header, cell data and footer. Compared with the first generation it adds build-time header, footer, sync and cell-repeat geometry, a per-frame sequence number, burst-limited frame counts, and underflow detection when no pattern is ready at a frame trigger. It sits between the pattern source (AXI-Stream style) and the LVDS serialiser.

---
 rtl/sensor_emu_gen2.sv | 147 ++++++++++++++
 tb/tb_sensor_emu_gen2.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_emu_gen2.sv
// Frame generator: idle pattern, header, cell data and footer on a wide LVDS bus.
// Optional SENSOR_EMU_SEQNUM_EN puts a per-frame sequence number in header cycles 4-7.
module sensor_emu_gen2 #(
   parameter int PATTERN_WIDTH     = 32,
   parameter int LVDS_WIDTH        = 512,
   parameter int HEADER_CYCLES     = 16,
   parameter int FOOTER_CYCLES     = 4,
   parameter int SYNC_PERIOD       = 256,
   parameter int SYNC_PULSE_LENGTH = 4,
   parameter int CELL_REPEAT       = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     rs0,
   input  logic                     rs256,
   input  logic [31:0]              cycles_per_frame,
   input  logic [31:0]              frame_limit,
   input  logic                     arm,
   input  logic [7:0]               idle_0,
   input  logic [7:0]               idle_1,
   input  logic [31:0]              frame_header,
   output logic                     pa_sync,
   output logic [LVDS_WIDTH-1:0]    lvds,
   output logic                     sof,
   output logic                     eof,
   output logic                     done,
   output logic [31:0]              frames_sent,
   output logic [15:0]              underflow_count,
   input  logic [PATTERN_WIDTH-1:0] PATTERN_TDATA,
   input  logic                     PATTERN_TVALID,
   output logic                     PATTERN_TREADY
);

   localparam int TW  = $clog2(SYNC_PERIOD);
   localparam int CRB = $clog2(CELL_REPEAT);
   localparam int NB  = LVDS_WIDTH / 8;
   localparam logic [31:0]   MIN_CPF  = 32'(HEADER_CYCLES + FOOTER_CYCLES + 2);
   localparam logic [31:0]   HDR_LAST = 32'(HEADER_CYCLES - 1);
   localparam logic [31:0]   FTR_LEN  = 32'(FOOTER_CYCLES);
   localparam logic [TW-1:0] PULSE    = TW'(SYNC_PULSE_LENGTH);
   localparam logic [TW-1:0] FT_ONE   = TW'(1);

   typedef enum logic [2:0] {S_RESET, S_IDLE0, S_IDLE1, S_HDR, S_DATA, S_FTR} state_t;

   state_t        state, state_next;
   logic [TW-1:0] free_timer;
   logic [31:0]   cycle_number;
   logic [63:0]   ext;
   logic [31:0]   eff_cpf;
   logic          trig, decide, start, lost, frame_end;
   logic [2:0]    data_sel;
   logic [7:0]    fill;
   logic          ramp;

   assign eff_cpf   = (cycles_per_frame > MIN_CPF) ? cycles_per_frame : MIN_CPF;
   assign frame_end = (cycle_number == eff_cpf - 32'd1);
   assign trig      = (rs0 | rs256) & (free_timer == '0) & ~done;
   assign pa_sync   = PATTERN_TVALID & (free_timer < PULSE);
   assign sof       = (state == S_HDR);
   assign eof       = (state == S_FTR);

   always_ff @(posedge clk) begin
      if (!resetn) state <= S_RESET;
      else         state <= state_next;
   end

   // The last footer cycle doubles as an IDLE1 decision point for back-to-back frames.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      lost       = 1'b0;
      decide     = (state == S_IDLE1) || ((state == S_FTR) && frame_end);
      case (state)
         S_RESET: state_next = S_IDLE0;
         S_IDLE0: state_next = S_IDLE1;
         S_HDR:   if (cycle_number == HDR_LAST) state_next = S_DATA;
         S_DATA:  if (cycle_number == eff_cpf - 32'd1 - FTR_LEN) state_next = S_FTR;
         default: state_next = state;
      endcase
      if (decide) begin
         if (trig && PATTERN_TVALID) begin
            start      = 1'b1;
            state_next = S_HDR;
         end else begin
            lost       = trig;
            state_next = S_IDLE0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         free_timer      <= '0;
         cycle_number    <= '0;
         ext             <= '0;
         PATTERN_TREADY  <= 1'b0;
         frames_sent     <= '0;
         underflow_count <= '0;
         done            <= 1'b0;
      end else begin
         free_timer     <= free_timer + FT_ONE;
         cycle_number   <= start ? 32'd0 : cycle_number + 32'd1;
         PATTERN_TREADY <= start;
         if (start) ext <= {(64 / PATTERN_WIDTH){PATTERN_TDATA}};
         // arm beats a coincident frame start: the count restarts at that frame
         if (arm)        frames_sent <= start ? 32'd1 : 32'd0;
         else if (start) frames_sent <= frames_sent + 32'd1;
         if (arm) done <= 1'b0;
         else if ((frame_limit != 32'd0) && (frames_sent == frame_limit)) done <= 1'b1;
         if (lost && (underflow_count != 16'hFFFF)) underflow_count <= underflow_count + 16'd1;
      end
   end

`ifdef SENSOR_EMU_SEQNUM_EN
   logic [31:0] seq_cnt, seq_cur;

   // Counts frames since reset; arm leaves it alone.
   always_ff @(posedge clk) begin
      if (!resetn)    seq_cnt <= '0;
      else if (start) seq_cnt <= seq_cnt + 32'd1;
   end
   assign seq_cur = seq_cnt - 32'd1;
`endif

   assign data_sel = 3'd7 - cycle_number[CRB +: 3];

   always_comb begin
      fill = 8'h00;
      ramp = 1'b0;
      case (state)
         S_IDLE0: fill = idle_0;
         S_IDLE1: fill = idle_1;
         S_HDR: begin
            if (cycle_number < 32'd4) fill = frame_header[{cycle_number[1:0], 3'b000} +: 8];
`ifdef SENSOR_EMU_SEQNUM_EN
            else if (cycle_number < 32'd8) fill = seq_cur[{cycle_number[1:0], 3'b000} +: 8];
`endif
            else if (cycle_number == 32'd11) ramp = 1'b1;
         end
         S_DATA:  fill = ext[{data_sel, 3'b000} +: 8];
         default: fill = 8'h00;
      endcase
      lvds = '0;
      for (int i = 0; i < NB; i++) lvds[8*i +: 8] = ramp ? 8'(i) : fill;
   end

endmodule

// File: tb/tb_sensor_emu_gen2.sv
// Bench for sensor_emu_gen2: directed scenarios plus random traffic against a frame-position model.
module tb_sensor_emu_gen2;
   localparam int PW = 32, LW = 128, HC = 16, FC = 4, SP = 32, SPL = 4, CR = 4;
   localparam int MINC = HC + FC + 2;

   logic          clk;
   logic          resetn, rs0, rs256, arm, PATTERN_TVALID;
   logic [31:0]   cycles_per_frame, frame_limit, frame_header;
   logic [7:0]    idle_0, idle_1;
   logic [PW-1:0] PATTERN_TDATA;
   logic          pa_sync, sof, eof, done, PATTERN_TREADY;
   logic [LW-1:0] lvds;
   logic [31:0]   frames_sent;
   logic [15:0]   underflow_count;

   sensor_emu_gen2 #(
      .PATTERN_WIDTH(PW), .LVDS_WIDTH(LW), .HEADER_CYCLES(HC), .FOOTER_CYCLES(FC),
      .SYNC_PERIOD(SP), .SYNC_PULSE_LENGTH(SPL), .CELL_REPEAT(CR)
   ) dut (
      .clk(clk), .resetn(resetn), .rs0(rs0), .rs256(rs256),
      .cycles_per_frame(cycles_per_frame), .frame_limit(frame_limit), .arm(arm),
      .idle_0(idle_0), .idle_1(idle_1), .frame_header(frame_header),
      .pa_sync(pa_sync), .lvds(lvds), .sof(sof), .eof(eof), .done(done),
      .frames_sent(frames_sent), .underflow_count(underflow_count),
      .PATTERN_TDATA(PATTERN_TDATA), .PATTERN_TVALID(PATTERN_TVALID),
      .PATTERN_TREADY(PATTERN_TREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0;

   // Model: mode 0 reset, 1 idle_0 shown, 2 idle_1 shown, 3 inside a frame at position m_pos.
   int          m_mode = 0, m_pos = 0, m_ft = 0;
   logic [31:0] m_fs = 0, m_seq = 0;
   int          m_uc = 0;
   logic        m_done = 0, m_rdy = 0;
   logic [63:0] m_ext = 0;

   int   n_sof_rise = 0, n_rdy = 0, cur_len = 0, last_len = 0;
   logic prev_sof = 0, prev_eof = 0, in_fr = 0;

   function automatic int eff_now();
      return (int'(cycles_per_frame) > MINC) ? int'(cycles_per_frame) : MINC;
   endfunction

   function automatic logic [LW-1:0] exp_lvds();
      logic [7:0]    b;
      logic [LW-1:0] r;
      logic [31:0]   sq;
      b = 8'h00;
      r = '0;
      sq = m_seq - 32'd1;
      if (m_mode == 1) b = idle_0;
      else if (m_mode == 2) b = idle_1;
      else if (m_mode == 3) begin
         if (m_pos < HC) begin
            if (m_pos < 4) b = 8'(frame_header >> (8 * m_pos));
            else if (m_pos < 8) begin
`ifdef SENSOR_EMU_SEQNUM_EN
               b = 8'(sq >> (8 * (m_pos - 4)));
`else
               b = 8'h00;
`endif
            end else if (m_pos == 11) begin
               for (int i = 0; i < LW / 8; i++) r[8*i +: 8] = 8'(i % 256);
               return r;
            end
         end else if (m_pos < eff_now() - FC)
            b = 8'(m_ext >> (8 * (7 - ((m_pos / CR) % 8))));
      end
      for (int i = 0; i < LW / 8; i++) r[8*i +: 8] = b;
      return r;
   endfunction

   task automatic model_update();
      int   eff;
      logic trig, decide, start, n_done;
      if (!resetn) begin
         m_mode = 0; m_pos = 0; m_ft = 0; m_fs = 0; m_uc = 0;
         m_done = 0; m_rdy = 0; m_seq = 0;
      end else begin
         eff    = eff_now();
         trig   = (rs0 || rs256) && (m_ft == 0) && !m_done;
         decide = (m_mode == 2) || ((m_mode == 3) && (m_pos == eff - 1));
         start  = decide && trig && PATTERN_TVALID;
         n_done = arm ? 1'b0 : (m_done || ((frame_limit != 0) && (m_fs == frame_limit)));
         m_fs   = arm ? (start ? 32'd1 : 32'd0) : m_fs + (start ? 32'd1 : 32'd0);
         m_done = n_done;
         if (decide && trig && !PATTERN_TVALID && m_uc < 65535) m_uc++;
         m_rdy = start;
         if (start) begin
            m_ext = {PATTERN_TDATA, PATTERN_TDATA};
            m_seq = m_seq + 32'd1;
            m_mode = 3; m_pos = 0;
         end else if (decide) m_mode = 1;
         else if (m_mode == 0) m_mode = 1;
         else if (m_mode == 1) m_mode = 2;
         else m_pos++;
         m_ft = (m_ft + 1) % SP;
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chkv(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_cycle();
      int eff;
      eff = eff_now();
      chkv ("lvds", lvds, exp_lvds());
      chk32("sof", 32'(sof), 32'((m_mode == 3) && (m_pos < HC)));
      chk32("eof", 32'(eof), 32'((m_mode == 3) && (m_pos >= eff - FC)));
      chk32("tready", 32'(PATTERN_TREADY), 32'(m_rdy));
      chk32("frames_sent", frames_sent, m_fs);
      chk32("done", 32'(done), 32'(m_done));
      chk32("underflow", 32'(underflow_count), 32'(m_uc));
      chk32("pa_sync", 32'(pa_sync), 32'(PATTERN_TVALID && (m_ft < SPL)));
      if (prev_eof && !eof) begin last_len = cur_len; in_fr = 0; end
      if (sof && !prev_sof) begin in_fr = 1; cur_len = 0; n_sof_rise++; end
      if (in_fr) cur_len++;
      if (PATTERN_TREADY) n_rdy++;
      prev_sof = sof;
      prev_eof = eof;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic wait_idle();
      rs0 = 1'b0; rs256 = 1'b0;
      for (int k = 0; k < 200 && m_mode == 3; k++) tick();
      chk32("wait_idle_timeout", 32'(m_mode == 3), 32'd0);
   endtask

   int s0;

   initial begin
      resetn = 0; rs0 = 0; rs256 = 0; arm = 0; PATTERN_TVALID = 1;
      cycles_per_frame = 32; frame_limit = 1; frame_header = 32'h44332211;
      idle_0 = 8'h5A; idle_1 = 8'hA5; PATTERN_TDATA = 32'hA1B2C3D4;
      repeat (3) tick();
      chkv ("reset_lvds", lvds, '0);
      chk32("reset_frames", frames_sent, 32'd0);

      // single frame, burst of one
      resetn = 1; rs0 = 1;
      repeat (120) tick();
      chk32("single_sof_count", 32'(n_sof_rise), 32'd1);
      chk32("single_tready_count", 32'(n_rdy), 32'd1);
      chk32("single_len", 32'(last_len), 32'd32);
      chk32("single_done", 32'(done), 32'd1);

      // underflow: trigger with no pattern ready
      rs0 = 0; pulse_arm();
      frame_limit = 0; PATTERN_TVALID = 0; rs256 = 1;
      s0 = n_sof_rise;
      repeat (2 * SP) tick();
      chk32("uf_nonzero", 32'(underflow_count != 0), 32'd1);
      chk32("uf_no_sof", 32'(n_sof_rise), 32'(s0));

      // burst of three, then arm restarts the count
      rs256 = 0; PATTERN_TVALID = 1; frame_limit = 3; rs0 = 1;
      pulse_arm();
      s0 = n_sof_rise;
      repeat (300) tick();
      chk32("burst_sof_count", 32'(n_sof_rise), 32'(s0 + 3));
      chk32("burst_done", 32'(done), 32'd1);
      chk32("burst_frames", frames_sent, 32'd3);
      pulse_arm();
      for (int k = 0; k < 100 && n_sof_rise < s0 + 4; k++) tick();
      chk32("rearm_sof_count", 32'(n_sof_rise), 32'(s0 + 4));
      chk32("rearm_frames", frames_sent, 32'd1);

      // clamp a too-short frame length
      wait_idle();
      cycles_per_frame = 4; frame_limit = 1;
      pulse_arm();
      rs0 = 1;
      repeat (120) tick();
      chk32("clamp_len", 32'(last_len), 32'(MINC));

      // reset in the middle of the data phase
      wait_idle();
      cycles_per_frame = 32; frame_limit = 0;
      pulse_arm();
      rs0 = 1;
      for (int k = 0; k < 200 && !(m_mode == 3 && m_pos == 20); k++) tick();
      chk32("mid_reached_data", 32'(m_mode == 3 && m_pos == 20), 32'd1);
      resetn = 0;
      tick();
      chkv ("mid_reset_lvds", lvds, '0);
      chk32("mid_reset_frames", frames_sent, 32'd0);
      chk32("mid_reset_eof", 32'(eof), 32'd0);
      resetn = 1;

      // random traffic
      for (int k = 0; k < 4000; k++) begin
         rs0 = ($urandom_range(0, 3) == 0);
         rs256 = ($urandom_range(0, 5) == 0);
         PATTERN_TVALID = ($urandom_range(0, 3) != 0);
         PATTERN_TDATA = $urandom;
         arm = ($urandom_range(0, 39) == 0);
         idle_0 = 8'($urandom);
         idle_1 = 8'($urandom);
         frame_header = $urandom;
         if (m_mode != 3 && $urandom_range(0, 19) == 0) cycles_per_frame = $urandom_range(0, 40);
         if ($urandom_range(0, 49) == 0) frame_limit = $urandom_range(0, 4);
         resetn = ($urandom_range(0, 499) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
